scan_mux: RTL and testbench

Parametrised, registered N-to-1 multiplexer with valid/ready handshaking on every input channel and on the output. It supersedes the fixed combinational 16-to-1 mux in the Digital System Design labs. It selects a channel either from an external select (manual mode) or from an internal round-robin pointer (scan mode), and forwards one word per cycle through a single output register stage.

---
 rtl/scan_mux_pkg.sv | 18 +
 rtl/scan_mux_if.sv | 29 ++
 rtl/scan_mux_rr_pick.sv | 27 ++
 rtl/scan_mux.sv | 103 ++++++++++
 tb/tb_scan_mux.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/scan_mux_pkg.sv
// Shared mux constants and index helpers used by scan_mux and its channel picker.
// Pure functions and constants only; no logic or timing of its own.
package mux_pkg;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Index width for n channels, never narrower than one bit.
   function automatic int clog2(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Circular successor, explicit so non-power-of-two channel counts wrap correctly.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/scan_mux_if.sv
// Channel-side and output-side handshake bundle for scan_mux; master drives inputs, slave is the mux.
// No storage; ready/valid semantics are set by the attached mux.
interface scan_mux_if import mux_pkg::*; #(
   parameter int N_CH  = 16,
   parameter int WIDTH = 1
);
   localparam int SEL_W = clog2(N_CH);

   logic                  mode;
   logic [SEL_W-1:0]      sel;
   logic [N_CH*WIDTH-1:0] in_data;
   logic [N_CH-1:0]       in_valid;
   logic [N_CH-1:0]       in_ready;
   logic [WIDTH-1:0]      out_data;
   logic [SEL_W-1:0]      out_ch;
   logic                  out_valid;
   logic                  out_ready;

   modport master (
      output mode, sel, in_data, in_valid, out_ready,
      input  in_ready, out_data, out_ch, out_valid
   );

   modport slave (
      input  mode, sel, in_data, in_valid, out_ready,
      output in_ready, out_data, out_ch, out_valid
   );

endinterface

// File: rtl/scan_mux_rr_pick.sv
// rr_pick: combinational circular first-set finder over a request vector, starting at i_start.
// Zero latency; o_found low when no request bit is set.
module rr_pick import mux_pkg::*; #(
   parameter int N_CH  = 16,
   parameter int SEL_W = clog2(N_CH)
) (
   input  logic [N_CH-1:0]  i_req,
   input  logic [SEL_W-1:0] i_start,
   output logic [SEL_W-1:0] o_idx,
   output logic             o_found
);

   always_comb begin
      o_idx   = '0;
      o_found = 1'b0;
      for (int k = 0; k < N_CH; k++) begin
         int j;
         j = int'(i_start) + k;
         if (j >= N_CH) j = j - N_CH;
         if (!o_found && i_req[j]) begin
            o_found = 1'b1;
            o_idx   = SEL_W'(j);
         end
      end
   end

endmodule

// File: rtl/scan_mux.sv
// scan_mux: registered N:1 mux, manual select or round-robin scan (SCAN_MUX_SKIP_IDLE_EN: scan skips idle channels).
// Latency 1 cycle, 1 word/cycle; stall on !out_ready freezes output and pointer with all in_ready low.
module scan_mux import mux_pkg::*; #(
   parameter int N_CH  = 16,
   parameter int WIDTH = 1
) (
   input  logic       clk,
   input  logic       rst,
   scan_mux_if.slave  bus
);

   localparam int SEL_W = clog2(N_CH);

   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic [SEL_W-1:0] r_out_ch;
   logic [SEL_W-1:0] r_ptr;

   logic             w_load;
   logic             w_cand_ok;
   logic [SEL_W-1:0] w_cand;
   logic             w_cand_vld;
   logic [WIDTH-1:0] w_cand_dat;
   logic [N_CH-1:0]  w_rdy;
   logic             w_ptr_adv;
   logic [SEL_W-1:0] w_ptr_nxt;

   assign w_load = !r_out_valid || bus.out_ready;

`ifdef SCAN_MUX_SKIP_IDLE_EN
   logic [SEL_W-1:0] w_pick_idx;
   logic             w_pick_found;

   rr_pick #(.N_CH(N_CH), .SEL_W(SEL_W)) u_pick (
      .i_req   (bus.in_valid),
      .i_start (r_ptr),
      .o_idx   (w_pick_idx),
      .o_found (w_pick_found)
   );

   always_comb begin
      w_cand    = bus.sel;
      w_cand_ok = int'(bus.sel) < N_CH;
      if (bus.mode == MODE_SCAN) begin
         w_cand    = w_pick_idx;
         w_cand_ok = w_pick_found;
      end
   end
`else
   always_comb begin
      w_cand    = bus.sel;
      w_cand_ok = int'(bus.sel) < N_CH;
      if (bus.mode == MODE_SCAN) begin
         w_cand    = r_ptr;
         w_cand_ok = 1'b1;
      end
   end
`endif

   // Loop-built select keeps out-of-range sel from ever indexing past the bus.
   always_comb begin
      w_cand_vld = 1'b0;
      w_cand_dat = '0;
      w_rdy      = '0;
      for (int c = 0; c < N_CH; c++) begin
         if (w_cand_ok && int'(w_cand) == c) begin
            w_cand_vld = bus.in_valid[c];
            w_cand_dat = bus.in_data[c*WIDTH +: WIDTH];
         end
      end
      for (int c = 0; c < N_CH; c++) begin
         w_rdy[c] = w_load && w_cand_vld && !rst && (int'(w_cand) == c);
      end
   end

   // Scan slot is spent on every load, whether or not the slot's channel had data.
   assign w_ptr_adv = w_load && (bus.mode == MODE_SCAN) && w_cand_ok;
   assign w_ptr_nxt = SEL_W'(wrap_inc(int'(w_cand), N_CH));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_ch    <= '0;
         r_ptr       <= '0;
      end else begin
         if (w_load) begin
            r_out_valid <= w_cand_vld;
            if (w_cand_vld) begin
               r_out_data <= w_cand_dat;
               r_out_ch   <= w_cand;
            end
         end
         if (w_ptr_adv) r_ptr <= w_ptr_nxt;
      end
   end

   assign bus.in_ready  = w_rdy;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_ch    = r_out_ch;

endmodule

// File: tb/tb_scan_mux.sv
// Directed bench for scan_mux: 16-channel and 10-channel instances, 8-bit words (channel c carries base+c).
module tb_scan_mux;
   import mux_pkg::*;

   logic clk = 1'b0;
   logic rst_a;
   logic rst_b;

   always #5 clk = ~clk;

   scan_mux_if #(.N_CH(16), .WIDTH(8)) a_if ();
   scan_mux_if #(.N_CH(10), .WIDTH(8)) b_if ();

   scan_mux #(.N_CH(16), .WIDTH(8)) u_a (.clk(clk), .rst(rst_a), .bus(a_if));
   scan_mux #(.N_CH(10), .WIDTH(8)) u_b (.clk(clk), .rst(rst_b), .bus(b_if));

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic reset_a;
      rst_a = 1'b1;
      tick();
      rst_a = 1'b0;
   endtask

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      a_if.mode      = MODE_SCAN;
      a_if.sel       = '0;
      a_if.in_valid  = '1;
      a_if.out_ready = 1'b1;
      for (int c = 0; c < 16; c++) a_if.in_data[c*8 +: 8] = 8'(8'h30 + c);
      b_if.mode      = MODE_MANUAL;
      b_if.sel       = 4'd12;
      b_if.in_valid  = '1;
      b_if.out_ready = 1'b1;
      for (int c = 0; c < 10; c++) b_if.in_data[c*8 +: 8] = 8'(8'h50 + c);

      // Reset with every channel requesting.
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("rst_rdy%0d", k),   64'(a_if.in_ready),  64'h0);
         check($sformatf("rst_vld%0d", k),   64'(a_if.out_valid), 64'h0);
         check($sformatf("rst_dat%0d", k),   64'(a_if.out_data),  64'h0);
         check($sformatf("rst_ch%0d", k),    64'(a_if.out_ch),    64'h0);
      end
      check("rst_b_vld", 64'(b_if.out_valid), 64'h0);

      // Manual select of channel 5.
      rst_a = 1'b0;
      a_if.mode = MODE_MANUAL;
      a_if.sel  = 4'd5;
      #1;
      check("man_rdy0", 64'(a_if.in_ready), 64'h0020);
      for (int k = 0; k < 4; k++) begin
         tick();
         check($sformatf("man_vld%0d", k), 64'(a_if.out_valid), 64'h1);
         check($sformatf("man_dat%0d", k), 64'(a_if.out_data),  64'h35);
         check($sformatf("man_ch%0d", k),  64'(a_if.out_ch),    64'h5);
         check($sformatf("man_rdy%0d", k+1), 64'(a_if.in_ready), 64'h0020);
      end

      // Scan across all 16 channels and wrap; pointer untouched by manual mode.
      a_if.mode = MODE_SCAN;
      #1;
      check("scan_rdy_start", 64'(a_if.in_ready), 64'h0001);
      for (int k = 0; k < 17; k++) begin
         tick();
         check($sformatf("scan_vld%0d", k), 64'(a_if.out_valid), 64'h1);
         check($sformatf("scan_ch%0d", k),  64'(a_if.out_ch),    64'(k % 16));
         check($sformatf("scan_dat%0d", k), 64'(a_if.out_data),  64'(8'h30 + k % 16));
      end

      // Backpressure at channel 3 for four cycles.
      reset_a();
      for (int k = 0; k < 4; k++) begin
         tick();
         check($sformatf("bp_pre_ch%0d", k), 64'(a_if.out_ch), 64'(k));
      end
      a_if.out_ready = 1'b0;
      #1;
      check("bp_rdy_stall", 64'(a_if.in_ready), 64'h0);
      for (int k = 0; k < 4; k++) begin
         tick();
         check($sformatf("bp_ch%0d", k),  64'(a_if.out_ch),    64'h3);
         check($sformatf("bp_vld%0d", k), 64'(a_if.out_valid), 64'h1);
         check($sformatf("bp_dat%0d", k), 64'(a_if.out_data),  64'h33);
         check($sformatf("bp_rdy%0d", k), 64'(a_if.in_ready),  64'h0);
      end
      a_if.out_ready = 1'b1;
      #1;
      check("bp_rdy_release", 64'(a_if.in_ready), 64'h0010);
      tick();
      check("bp_post_ch4", 64'(a_if.out_ch), 64'h4);
      tick();
      check("bp_post_ch5", 64'(a_if.out_ch), 64'h5);

      // Only channels 0 and 4 valid.
      a_if.in_valid = 16'h0011;
      reset_a();
      for (int k = 0; k < 8; k++) begin
         tick();
`ifdef SCAN_MUX_SKIP_IDLE_EN
         check($sformatf("idle_vld%0d", k), 64'(a_if.out_valid), 64'h1);
         check($sformatf("idle_ch%0d", k),  64'(a_if.out_ch),    (k % 2 == 0) ? 64'h0 : 64'h4);
`else
         check($sformatf("idle_vld%0d", k), 64'(a_if.out_valid), (k % 4 == 0) ? 64'h1 : 64'h0);
         check($sformatf("idle_ch%0d", k),  64'(a_if.out_ch),    (k < 4) ? 64'h0 : 64'h4);
`endif
      end

      // 10-channel instance: out-of-range select, boundary select, then scan wrap.
      rst_b = 1'b0;
      #1;
      check("bad_sel_rdy0", 64'(b_if.in_ready), 64'h0);
      for (int k = 0; k < 4; k++) begin
         tick();
         check($sformatf("bad_sel_vld%0d", k), 64'(b_if.out_valid), 64'h0);
         check($sformatf("bad_sel_rdy%0d", k+1), 64'(b_if.in_ready), 64'h0);
      end
      b_if.sel = 4'd10;
      #1;
      check("sel10_rdy", 64'(b_if.in_ready), 64'h0);
      tick();
      check("sel10_vld", 64'(b_if.out_valid), 64'h0);
      b_if.sel = 4'd9;
      #1;
      check("sel9_rdy", 64'(b_if.in_ready), 64'h200);
      tick();
      check("sel9_vld", 64'(b_if.out_valid), 64'h1);
      check("sel9_ch",  64'(b_if.out_ch),    64'h9);
      check("sel9_dat", 64'(b_if.out_data),  64'h59);
      b_if.mode = MODE_SCAN;
      #1;
      check("b_scan_rdy_start", 64'(b_if.in_ready), 64'h001);
      for (int k = 0; k < 11; k++) begin
         tick();
         check($sformatf("b_scan_ch%0d", k),  64'(b_if.out_ch),   64'(k % 10));
         check($sformatf("b_scan_dat%0d", k), 64'(b_if.out_data), 64'(8'h50 + k % 10));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
